// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states and instruction-buffer entry.
package ifu_pkg;

  localparam int REG_END_WORD = 31;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [REG_END_WORD:0] word;
    logic [REG_END_WORD:0] pc;
  } ibuf_entry_t;

  function automatic logic [REG_END_WORD:0] word_align(input logic [REG_END_WORD:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous instruction buffer with push/pop/flush; head is a registered entry, no bypass.
// Latency: push visible at head the next cycle. Push on full is dropped unless a pop happens alongside.
module ifu_inst_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = $bits(ibuf_entry_t),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/gnt/rvalid, buffers for the decoder.
// Latency: rvalid -> inst_valid one cycle. Stops requesting when buffered + in-flight words fill the buffer.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  ifu_state_t                state;
  logic [REG_END_WORD:0]     pc;
  logic [REG_END_WORD:0]     fetch_pc;
  logic                      stale;
  logic                      push;
  logic                      pop;
  logic [CW-1:0]             fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW:0]               occ_nxt;
  ibuf_entry_t               push_dat;
  ibuf_entry_t               head_dat;

  // Redirect wins over every buffer update in its cycle.
  assign push     = (state == IFU_WAIT) & imem_rvalid & ~stale & ~redirect_valid;
  assign pop      = inst_valid & inst_ready & ~redirect_valid;
  assign push_dat = '{word: imem_rdata, pc: fetch_pc};
  assign occ_nxt  = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

  assign inst_valid = ~fifo_empty;
  assign inst       = head_dat.word;
  assign inst_pc    = head_dat.pc;

  ifu_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ibuf_entry_t))
  ) u_inst_fifo (
    .clk      (clock),
    .rst_n    (reset_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IFU_IDLE;
      pc        <= RESET_PC;
      fetch_pc  <= '0;
      stale     <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
      case (state)
        IFU_REQ: begin
          imem_req <= 1'b0;
          if (imem_gnt) begin
            // The granted word will still come back; mark it for discard.
            state    <= IFU_WAIT;
            stale    <= 1'b1;
            fetch_pc <= imem_addr;
          end else begin
            state <= IFU_IDLE;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            state <= IFU_IDLE;
            stale <= 1'b0;
          end else begin
            stale <= 1'b1;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end else begin
      case (state)
        IFU_IDLE: begin
          if (!fifo_full) begin
            state     <= IFU_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        IFU_REQ: begin
          if (imem_gnt) begin
            state    <= IFU_WAIT;
            imem_req <= 1'b0;
            fetch_pc <= imem_addr;
            pc       <= pc + 32'd4;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            stale <= 1'b0;
            // Occupancy after this cycle's push/pop decides whether another fetch fits.
            if (occ_nxt < DEPTH_L) begin
              state     <= IFU_REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else begin
              state <= IFU_IDLE;
            end
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: responding memory model plus grant/consume monitors.
module tb_ifu;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  logic        gnt_en;
  logic        rsp_en;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] gq[$];
  logic [31:0] cpc[$];
  logic [31:0] cword[$];
  int          gbase;
  int          cbase;

  ifu #(
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: grants whenever enabled, answers at gnt+1 when responses are enabled.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    pend_addr   = '0;
    forever begin
      @(negedge clock);
      imem_rvalid = 1'b0;
      if (pend && rsp_en) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end
      imem_gnt = imem_req && gnt_en;
      if (imem_gnt) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && imem_req && imem_gnt) gq.push_back(imem_addr);
    if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
      cpc.push_back(inst_pc);
      cword.push_back(inst);
    end
  end

  task automatic wait_grants(input int n, input string tag);
    for (int i = 0; i < 300 && gq.size() < n; i++) @(negedge clock);
    chk(tag, 32'(gq.size() >= n), 32'd1);
  endtask

  task automatic wait_insts(input int n, input string tag);
    for (int i = 0; i < 300 && cpc.size() < n; i++) @(negedge clock);
    chk(tag, 32'(cpc.size() >= n), 32'd1);
  endtask

  task automatic reset_dut(input logic g, input logic r, input logic rdy);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    repeat (3) @(negedge clock);
    gnt_en     = g;
    rsp_en     = r;
    inst_ready = rdy;
    gbase      = gq.size();
    cbase      = cpc.size();
    reset_n    = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req),   32'd0);
    chk({tag, "_addr"},  imem_addr,       32'h8000_0000);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst,            32'h0);
    chk({tag, "_pc"},    inst_pc,         32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    gnt_en         = 1'b0;
    rsp_en         = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_outputs("rst");

    // 1: streaming fetch with an always-ready decoder
    gnt_en     = 1'b1;
    inst_ready = 1'b1;
    gbase      = gq.size();
    cbase      = cpc.size();
    reset_n    = 1'b1;
    @(negedge clock);
    chk("t1_first_req", 32'(imem_req), 32'd1);
    chk("t1_first_addr", imem_addr, 32'h8000_0000);
    wait_insts(cbase + 3, "t1_wait");
    for (int k = 0; k < 3; k++) begin
      chk("t1_pc",   cpc[cbase + k],   32'h8000_0000 + 32'(4 * k));
      chk("t1_word", cword[cbase + k], mem_word(32'h8000_0000 + 32'(4 * k)));
    end

    // 2: stalled decoder fills the buffer, then drains in order
    reset_dut(1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    chk("t2_grants", 32'(gq.size() - gbase), 32'd2);
    chk("t2_req_low", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h8000_0000);
    chk("t2_head_word", inst, mem_word(32'h8000_0000));
    inst_ready = 1'b1;
    wait_insts(cbase + 4, "t2_wait");
    for (int k = 0; k < 4; k++) begin
      chk("t2_pc",   cpc[cbase + k],   32'h8000_0000 + 32'(4 * k));
      chk("t2_word", cword[cbase + k], mem_word(32'h8000_0000 + 32'(4 * k)));
    end

    // 3: redirect while a fetch is outstanding; returned word is stale
    reset_dut(1'b1, 1'b0, 1'b1);
    wait_grants(gbase + 1, "t3_wait_gnt");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("t3_valid_after_redir", 32'(inst_valid), 32'd0);
    rsp_en = 1'b1;
    wait_grants(gbase + 2, "t3_wait_gnt2");
    chk("t3_next_addr", gq[gbase + 1], 32'h0000_0100);
    wait_insts(cbase + 1, "t3_wait_inst");
    chk("t3_first_pc",   cpc[cbase],   32'h0000_0100);
    chk("t3_first_word", cword[cbase], mem_word(32'h0000_0100));

    // 4: grant withheld; request held stable, redirect drops it
    reset_dut(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t4_req_held",  32'(imem_req), 32'd1);
      chk("t4_addr_held", imem_addr,     32'h8000_0000);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("t4_req_dropped", 32'(imem_req), 32'd0);
    @(negedge clock);
    chk("t4_req_again", 32'(imem_req), 32'd1);
    chk("t4_new_addr",  imem_addr,     32'h0000_0200);
    gnt_en = 1'b1;
    wait_grants(gbase + 1, "t4_wait_gnt");
    chk("t4_gnt_addr", gq[gbase], 32'h0000_0200);

    // 5: PC wraps from the top of the address space
    reset_dut(1'b0, 1'b1, 1'b1);
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    gnt_en         = 1'b1;
    wait_grants(gbase + 2, "t5_wait_gnt");
    chk("t5_addr_top",  gq[gbase],     32'hFFFF_FFFC);
    chk("t5_addr_wrap", gq[gbase + 1], 32'h0000_0000);
    wait_insts(cbase + 2, "t5_wait_inst");
    chk("t5_pc_top",  cpc[cbase],     32'hFFFF_FFFC);
    chk("t5_pc_wrap", cpc[cbase + 1], 32'h0000_0000);

    // 6: reset while waiting; the late response lands during reset
    reset_dut(1'b1, 1'b0, 1'b1);
    wait_grants(gbase + 1, "t6_wait_gnt");
    reset_n = 1'b0;
    rsp_en  = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_outputs("t6_rst");
    gbase   = gq.size();
    cbase   = cpc.size();
    reset_n = 1'b1;
    wait_grants(gbase + 1, "t6_wait_gnt2");
    chk("t6_gnt_addr", gq[gbase], 32'h8000_0000);
    wait_insts(cbase + 1, "t6_wait_inst");
    chk("t6_first_pc",   cpc[cbase],   32'h8000_0000);
    chk("t6_first_word", cword[cbase], mem_word(32'h8000_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
